// File: rtl/bcd_digit_entry.sv
// ============================================================================
//  Module   : bcd_digit_entry
//  Purpose  : Assembles decimal key presses into a signed 9-bit value
//             {sign, magnitude 0..255}. It drives a live preview for the
//             7-segment BCD display driver while the user types, and commits
//             the value with a one-cycle valid pulse on ENTER.
//  Ports    : clk, rst (async, active-high)
//             i_key_valid / i_key_code : key strobe and code
//                 0-9 digit, 10 SIGN, 11 CLEAR, 12 ENTER, 13 BACKSPACE
//             o_disp_val / o_disp_en   : display preview and its enable
//             o_value / o_value_valid  : committed value and its pulse
//             o_err                    : one-cycle pulse on a rejected key
//             o_digit_cnt              : digits currently entered (0..3)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_entry #(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int SHOW_CYC    = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    output logic [8:0] o_disp_val,
    output logic       o_disp_en,
    output logic [8:0] o_value,
    output logic       o_value_valid,
    output logic       o_err,
    output logic [1:0] o_digit_cnt
);

    localparam logic [3:0] c_KEY_SIGN  = 4'd10;
    localparam logic [3:0] c_KEY_CLEAR = 4'd11;
    localparam logic [3:0] c_KEY_ENTER = 4'd12;
    localparam logic [3:0] c_KEY_BKSP  = 4'd13;

    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int c_SH_W = $clog2(SHOW_CYC + 1);
    // Timers count down to zero; loading N-1 makes expiry fire on the Nth
    // idle edge after the load.
    localparam logic [c_TO_W-1:0] c_TO_LOAD = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_SH_W-1:0] c_SH_LOAD = c_SH_W'(SHOW_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_acc;
    logic              r_sign;
    logic [1:0]        r_cnt;
    logic [8:0]        r_value;
    logic              r_vv;
    logic              r_err;
    logic              r_disp_en;
    logic [8:0]        r_disp_val;
    logic [c_TO_W-1:0] r_to;
    logic [c_SH_W-1:0] r_show;

    state_t            w_state_n;
    logic [7:0]        w_acc_n;
    logic              w_sign_n;
    logic [1:0]        w_cnt_n;
    logic [8:0]        w_value_n;
    logic              w_vv_n;
    logic              w_err_n;
    logic [c_TO_W-1:0] w_to_n;
    logic [c_SH_W-1:0] w_show_n;
    logic [11:0]       w_new;
    logic              w_is_digit;

    assign w_is_digit = (i_key_code <= 4'd9);
    // Wide enough for 255*10+9, so overflow is detected rather than wrapped.
    assign w_new      = ({4'd0, r_acc} * 12'd10) + {8'd0, i_key_code};

    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_sign_n  = r_sign;
        w_cnt_n   = r_cnt;
        w_value_n = r_value;
        w_vv_n    = 1'b0;
        w_err_n   = 1'b0;
        w_to_n    = r_to;
        w_show_n  = r_show;

        case (r_state)
            ST_ENTRY: begin
                if (i_key_valid) begin
                    w_to_n = c_TO_LOAD;
                    if (w_is_digit) begin
                        if ((r_cnt < 2'd3) && (w_new <= 12'd255)) begin
                            w_acc_n = w_new[7:0];
                            w_cnt_n = r_cnt + 2'd1;
                        end else begin
                            w_err_n = 1'b1;
                        end
                    end else if (i_key_code == c_KEY_SIGN) begin
                        w_sign_n = ~r_sign;
                    end else if (i_key_code == c_KEY_BKSP) begin
                        if (r_cnt != 2'd0) begin
                            w_acc_n = r_acc / 8'd10;
                            w_cnt_n = r_cnt - 2'd1;
                        end else begin
                            w_err_n = 1'b1;
                        end
                    end else if (i_key_code == c_KEY_CLEAR) begin
                        w_acc_n   = 8'd0;
                        w_sign_n  = 1'b0;
                        w_cnt_n   = 2'd0;
                        w_state_n = ST_IDLE;
                    end else if (i_key_code == c_KEY_ENTER) begin
                        if (r_cnt == 2'd0) begin
                            w_err_n = 1'b1;
                        end else begin
                            // A negative zero is committed as plus zero.
                            w_value_n = {r_sign & (r_acc != 8'd0), r_acc};
                            w_vv_n    = 1'b1;
                            w_acc_n   = 8'd0;
                            w_sign_n  = 1'b0;
                            w_cnt_n   = 2'd0;
                            w_show_n  = c_SH_LOAD;
                            w_state_n = ST_SHOW;
                        end
                    end
                end else if (r_to == '0) begin
                    w_acc_n   = 8'd0;
                    w_sign_n  = 1'b0;
                    w_cnt_n   = 2'd0;
                    w_state_n = ST_IDLE;
                end else begin
                    w_to_n = r_to - 1'b1;
                end
            end

            default: begin
                // IDLE and SHOW share key handling; a key in SHOW is acted on
                // in the same cycle so typing can start without waiting.
                if (i_key_valid) begin
                    if (w_is_digit) begin
                        w_acc_n   = {4'd0, i_key_code};
                        w_sign_n  = 1'b0;
                        w_cnt_n   = 2'd1;
                        w_to_n    = c_TO_LOAD;
                        w_state_n = ST_ENTRY;
                    end else if (i_key_code == c_KEY_SIGN) begin
                        w_acc_n   = 8'd0;
                        w_sign_n  = 1'b1;
                        w_cnt_n   = 2'd0;
                        w_to_n    = c_TO_LOAD;
                        w_state_n = ST_ENTRY;
                    end else if (i_key_code == c_KEY_ENTER) begin
                        w_err_n = 1'b1;
                    end else if ((i_key_code == c_KEY_CLEAR) && (r_state == ST_SHOW)) begin
                        w_state_n = ST_IDLE;
                    end
                end else if (r_state == ST_SHOW) begin
                    if (r_show == '0) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_show_n = r_show - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_acc      <= 8'd0;
            r_sign     <= 1'b0;
            r_cnt      <= 2'd0;
            r_value    <= 9'd0;
            r_vv       <= 1'b0;
            r_err      <= 1'b0;
            r_disp_en  <= 1'b0;
            r_disp_val <= 9'd0;
            r_to       <= '0;
            r_show     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_acc     <= w_acc_n;
            r_sign    <= w_sign_n;
            r_cnt     <= w_cnt_n;
            r_value   <= w_value_n;
            r_vv      <= w_vv_n;
            r_err     <= w_err_n;
            r_to      <= w_to_n;
            r_show    <= w_show_n;
            r_disp_en <= (w_state_n != ST_IDLE);
            case (w_state_n)
                ST_ENTRY: r_disp_val <= {w_sign_n, w_acc_n};
                ST_SHOW:  r_disp_val <= w_value_n;
                default:  r_disp_val <= 9'd0;
            endcase
        end
    end

    assign o_disp_val    = r_disp_val;
    assign o_disp_en     = r_disp_en;
    assign o_value       = r_value;
    assign o_value_valid = r_vv;
    assign o_err         = r_err;
    assign o_digit_cnt   = r_cnt;

endmodule

`default_nettype wire
